// File: rtl/mult_seq_ctrl.sv
// Two-requester round-robin shift-add multiplier: capture, MULTLEN_2 RUN edges, then DONE.
// Product and out_id are held in DONE until out_ready; requests are ignored while busy.
module mult_seq_ctrl #(
  parameter int MULTLEN_1 = 4,
  parameter int MULTLEN_2 = 4,
  localparam int W = MULTLEN_1 + MULTLEN_2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [MULTLEN_1-1:0] a0,
  input  logic [MULTLEN_1-1:0] a1,
  input  logic [MULTLEN_2-1:0] b0,
  input  logic [MULTLEN_2-1:0] b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_id,
  output logic [W-1:0]         product
);

  localparam int CW = (MULTLEN_2 > 1) ? $clog2(MULTLEN_2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULTLEN_2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 last_id, last_id_nxt;
  logic [W-1:0]         acc, acc_nxt;
  logic [W-1:0]         mcand, mcand_nxt;
  logic [MULTLEN_2-1:0] mplier, mplier_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 ack0_nxt, ack1_nxt;
  logic                 out_id_nxt;
  logic [W-1:0]         product_nxt;

  logic                 grant_id;
  logic [W-1:0]         step_sum;

  // Tie goes to the requester that did not win last; a lone request wins outright.
  assign grant_id = (req0 && req1) ? ~last_id : req1;
  assign step_sum = mplier[0] ? (acc + mcand) : acc;

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt   = state;
    last_id_nxt = last_id;
    acc_nxt     = acc;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    cnt_nxt     = cnt;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    out_id_nxt  = out_id;
    product_nxt = product;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt   = RUN;
          last_id_nxt = grant_id;
          out_id_nxt  = grant_id;
          mcand_nxt   = grant_id ? {{MULTLEN_2{1'b0}}, a1} : {{MULTLEN_2{1'b0}}, a0};
          mplier_nxt  = grant_id ? b1 : b0;
          acc_nxt     = '0;
          cnt_nxt     = '0;
          ack0_nxt    = ~grant_id;
          ack1_nxt    = grant_id;
        end
      end
      RUN: begin
        // Fixed MULTLEN_2 steps regardless of operand values, so latency is constant.
        acc_nxt    = step_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          state_nxt   = DONE;
          product_nxt = step_sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      out_id  <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      last_id <= last_id_nxt;
      acc     <= acc_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      cnt     <= cnt_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      out_id  <= out_id_nxt;
      product <= product_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations and a random soak.
module tb_mult_seq_ctrl;

  localparam int M1 = 4;
  localparam int M2 = 4;
  localparam int W  = M1 + M2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [M1-1:0] a0 = '0, a1 = '0;
  logic [M2-1:0] b0 = '0, b1 = '0;
  logic          ack0, ack1, busy, out_valid, out_id;
  logic          out_ready = 1'b1;
  logic [W-1:0]  product;

  int checks   = 0;
  int failures = 0;

  mult_seq_ctrl #(.MULTLEN_1(M1), .MULTLEN_2(M2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing (countdown), 2 holding result.
  int           m_st   = 0;
  int           m_left = 0;
  int           m_ops  = 0;
  bit           m_last = 1'b1;
  bit           m_init = 1'b0;
  bit           w;
  logic [W-1:0] m_pend = '0;
  logic         e_ack0 = 1'b0, e_ack1 = 1'b0, e_id = 1'b0;
  logic [W-1:0] e_prod = '0;

  always @(posedge clk) begin
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (rst) begin
      m_st   = 0;
      m_last = 1'b1;
      e_id   = 1'b0;
      e_prod = '0;
      m_init = 1'b1;
    end else if (m_st == 0) begin
      if (req0 || req1) begin
        w      = (req0 && req1) ? !m_last : req1;
        m_last = w;
        e_id   = w;
        e_ack0 = !w;
        e_ack1 = w;
        m_pend = w ? (W'(a1) * W'(b1)) : (W'(a0) * W'(b0));
        m_left = M2;
        m_st   = 1;
      end
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_st   = 2;
        e_prod = m_pend;
      end
    end else if (out_ready) begin
      m_st = 0;
      m_ops++;
    end
    #1;
    if (m_init) begin
      chk("model_ack0", ack0, e_ack0);
      chk("model_ack1", ack1, e_ack1);
      chk("ack_exclusive", ack0 & ack1, 0);
      chk("model_busy", busy, m_st != 0);
      chk("model_out_valid", out_valid, m_st == 2);
      chk("model_out_id", out_id, e_id);
      chk("model_product", product, e_prod);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input bit id);
    int n = 0;
    while (!(id ? ack1 : ack0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(id ? "ack1_seen" : "ack0_seen", id ? ack1 : ack0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  task automatic run_op(input bit id, input logic [M1-1:0] a, input logic [M2-1:0] b, input int exp_p);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    wait_ack(id);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_valid(lat);
    chk("op_latency", lat, 4);
    chk("op_product", product, exp_p);
    chk("op_out_id", out_id, id);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int target;
    int cyc;
    bit got;
    int order [4];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", product, 0);

    // Single op and extremes
    run_op(1'b0, 4'd13, 4'd11, 143);
    run_op(1'b0, 4'd15, 4'd15, 225);
    run_op(1'b1, 4'd0, 4'd9, 0);
    run_op(1'b0, 4'd7, 4'd0, 0);

    // Tie after reset: grants alternate starting with requester 0
    do_reset();
    a0 = 4'd3; b0 = 4'd5; a1 = 4'd2; b1 = 4'd7;
    out_ready = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (!(ack0 || ack1) && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      got = ack1;
      order[i] = got;
      chk("tie_ack_seen", ack0 | ack1, 1);
      @(negedge clk);
    end
    chk("tie_grant0", order[0], 0);
    chk("tie_grant1", order[1], 1);
    chk("tie_grant2", order[2], 0);
    chk("tie_grant3", order[3], 1);
    req0 = 1'b0;
    req1 = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("tie_drain", busy, 0);

    // Backpressure in DONE with req1 waiting
    do_reset();
    out_ready = 1'b0;
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
    wait_ack(1'b0);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd3;
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", out_valid, 1);
      chk("bp_product", product, 42);
      chk("bp_out_id", out_id, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ack1", ack1, 0);
    @(negedge clk);
    chk("bp_req1_capture", ack1, 1);
    req1 = 1'b0;
    wait_valid(lat);
    chk("bp2_product", product, 15);
    chk("bp2_out_id", out_id, 1);
    @(negedge clk);

    // Reset on the second RUN edge, req0 held throughout
    do_reset();
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd12;
    wait_ack(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;
    wait_ack(1'b0);
    req0 = 1'b0;
    wait_valid(lat);
    chk("rst_restart_lat", lat, 4);
    chk("rst_restart_product", product, 108);
    @(negedge clk);

    // Random soak checked by the model
    target = m_ops + 1000;
    cyc = 0;
    while (m_ops < target && cyc < 40000) begin
      @(negedge clk);
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      a0        = M1'($urandom);
      a1        = M1'($urandom);
      b0        = M2'($urandom);
      b1        = M2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("random_ops_done", m_ops >= target, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter MULTLEN_1, default 4, meaning multiplicand width.
REQ-002 SHALL have parameter MULTLEN_2, default 4, meaning multiplier width and the number of shift-add steps.
REQ-003 SHALL define W = MULTLEN_1 + MULTLEN_2 as the product width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req0 / req1, input, 1 bit each: request from requester 0 / 1, level-held.
REQ-007 SHALL have ports a0 / a1, input, MULTLEN_1 bits: multiplicand of requester 0 / 1.
REQ-008 SHALL have ports b0 / b1, input, MULTLEN_2 bits: multiplier of requester 0 / 1.
REQ-009 SHALL have ports ack0 / ack1, input-accepted outputs, 1 bit each: one-cycle registered pulse when that requester's operands are captured.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN or DONE.
REQ-011 SHALL have port out_valid, output, 1 bit: product available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-013 SHALL have port out_id, output, 1 bit: requester index owning the product.
REQ-014 SHALL have port product, output, W bits: a*b result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE: at an edge with req0 or req1 high, SHALL select a winner, capture mcand = zero-extended a (W bits), mplier = b, acc = 0, cnt = 0, pulse the winner's ack for the following cycle, and go to RUN.
REQ-017 Arbitration SHALL be round-robin via register last_id: if both requests are high, grant !last_id; if one is high, grant it; on every grant set last_id to the winner.
REQ-018 RUN, each edge: if mplier[0], acc <= acc + mcand (mod 2^W), else acc unchanged; then mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
REQ-019 RUN SHALL last exactly MULTLEN_2 edges; on the edge where cnt = MULTLEN_2-1, the FSM goes to DONE with product = final acc.
REQ-020 Latency: out_valid SHALL rise MULTLEN_2 edges after the capture edge, independent of operand values (no early termination).
REQ-021 DONE: out_valid = 1; product and out_id SHALL hold stable until an edge with out_ready = 1, then go to IDLE with out_valid = 0.
REQ-022 Requests SHALL be ignored in RUN and DONE; a request dropped before being sampled in IDLE is never served.
REQ-023 Minimum spacing between captures SHALL be MULTLEN_2 + 2 cycles (RUN, DONE with out_ready held high, IDLE).
REQ-024 The product SHALL be exact: product = a * b with no overflow, since W = MULTLEN_1 + MULTLEN_2.
REQ-025 Operands of zero SHALL still take the full latency and yield product 0.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-027 While rst is high at an edge, the block SHALL set: FSM = IDLE, ack0 = ack1 = 0, busy = 0, out_valid = 0, out_id = 0, product = 0, acc / mcand / mplier / cnt = 0, and last_id = 1 (requester 0 wins the first tie).
REQ-028 A reset during RUN or DONE SHALL abort the operation with no out_valid; requests still pending after reset SHALL be re-arbitrated from IDLE.

Verification
REQ-029 Single op, 4x4 defaults: req0 with a0 = 13, b0 = 11 -> ack0 pulses once; out_valid rises 4 edges after capture; product = 143, out_id = 0.
REQ-030 Extremes: a = 15, b = 15 -> product 225; a = 0, b = 9 -> product 0; a = 7, b = 0 -> product 0; every case has 4-edge latency.
REQ-031 Tie after reset: req0 and req1 held high -> grant order 0, 1, 0, 1; out_id alternates accordingly; ack0 and ack1 are never high together.
REQ-032 Backpressure: out_ready = 0 for 10 cycles in DONE -> product and out_id stable and out_valid held; out_ready = 1 -> IDLE next edge; a waiting req1 is captured the edge after.
REQ-033 Reset mid-RUN: rst asserted on the 2nd RUN edge -> all outputs 0 next cycle, no out_valid; after release, a pending req0 restarts and returns the correct product.
REQ-034 Random: 1000 random operand pairs with random out_ready -> every product equals the a*b model, in requester-grant order.
